// File: rtl/iter_shift_ctrl_if.sv
// Request/result bundle for iter_shift_ctrl.
// master drives the request side, slave (the shifter) drives the result side.
interface iter_shift_ctrl_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CW    = 4
);
    logic             start;
    logic [WIDTH-1:0] in;
    logic [CW-1:0]    cnt;
    logic [1:0]       op;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             done;

    modport master (
        output start, in, cnt, op,
        input  out, busy, done
    );

    modport slave (
        input  start, in, cnt, op,
        output out, busy, done
    );
endinterface

// File: rtl/iter_shift_ctrl.sv
// Iterative shifter/rotator: applies a cnt-position shift as cnt single-bit
// steps, one per clock, through one 1-bit shift stage.
// op: 00 rotate left, 01 logical left, 10 arithmetic right, 11 logical right.
// WIDTH must equal 2**CW.
module iter_shift_ctrl #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CW    = 4
) (
    input logic                clk,
    input logic                rst_n,
    iter_shift_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [CW-1:0]    rem_q, rem_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] step;

    // Single 1-bit shift stage selected by the latched op.
    always_comb begin
        step = out_q;
        unique case (op_q)
            2'b00: step = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
            2'b01: step = {out_q[WIDTH-2:0], 1'b0};
            2'b10: step = {out_q[WIDTH-1], out_q[WIDTH-1:1]};
            2'b11: step = {1'b0, out_q[WIDTH-1:1]};
            default: step = out_q;
        endcase
    end

    // Next-state: capture on start in idle, step while count remains, then one done cycle.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        rem_d   = rem_q;
        op_d    = op_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    out_d   = bus.in;
                    op_d    = bus.op;
                    rem_d   = bus.cnt;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (rem_q != '0) begin
                    out_d = step;
                    rem_d = rem_q - CW'(1);
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // start is deliberately ignored here; the next op starts from idle.
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            out_q   <= '0;
            rem_q   <= '0;
            op_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
        end
    end

    assign bus.out  = out_q;
    assign bus.busy = (state_q != StIdle);
    assign bus.done = (state_q == StDone);

endmodule
